// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: instruction/address widths, special encodings and
// the fetch-stage operating mode.
package legv8_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    localparam logic [INSTR_W-1:0] NOP_ENC  = 32'hD503201F;
    localparam logic [INSTR_W-1:0] HALT_ENC = 32'hD4400000;

    typedef enum logic {
        RUN,
        HALTED
    } fetch_mode_t;

endpackage

// File: rtl/if_fetch_unit.sv
// LEGv8 instruction-fetch stage: owns the PC, drives a 1-cycle synchronous
// instruction memory and presents each returned instruction with its PC.
module if_fetch_unit
    import legv8_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC   = 64'h0,
    parameter logic [INSTR_W-1:0] NOP_INSTR  = NOP_ENC,
    parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_ENC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_d,
    output logic [ADDR_W-1:0]  pc_d,
    output logic               halted,
    output logic [31:0]        fetch_count
);

    localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] pc_f, pc_f_n;
    logic              v_f, v_f_n;
    fetch_mode_t       mode, mode_n;
    logic [31:0]       count_q, count_n;
    logic [ADDR_W-1:0] target;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    assign target = {br_target[ADDR_W-1:2], 2'b00};

    // Next-state and output decode. Branch beats stall beats normal fetch.
    always_comb begin
        pc_n      = pc;
        pc_f_n    = pc_f;
        v_f_n     = v_f;
        mode_n    = mode;
        count_n   = count_q;
        imem_addr = pc;
        instr_d   = NOP_INSTR;

        if (mode == RUN) begin
            if (br_taken) begin
                // Squash the wrong-path instruction currently in IF.
                imem_addr = target;
                pc_f_n    = target;
                pc_n      = target + PC_STEP;
                v_f_n     = 1'b1;
            end else if (stall) begin
                // Re-read pc_f so the memory keeps returning the held word.
                imem_addr = pc_f;
                if (v_f) instr_d = imem_rdata;
            end else begin
                imem_addr = pc;
                pc_f_n    = pc;
                pc_n      = pc + PC_STEP;
                v_f_n     = 1'b1;
                if (v_f) begin
                    instr_d = imem_rdata;
                    count_n = sat_inc(count_q);
                    if (imem_rdata == HALT_INSTR) begin
                        mode_n = HALTED;
                        v_f_n  = 1'b0;
                    end
                end
            end
        end

        if (reset) begin
            imem_addr = RESET_PC;
            instr_d   = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            pc_f    <= RESET_PC;
            v_f     <= 1'b0;
            mode    <= RUN;
            count_q <= 32'd0;
        end else begin
            pc      <= pc_n;
            pc_f    <= pc_f_n;
            v_f     <= v_f_n;
            mode    <= mode_n;
            count_q <= count_n;
        end
    end

    assign pc_d        = reset ? RESET_PC : pc_f;
    assign halted      = !reset && (mode == HALTED);
    assign fetch_count = count_q;

endmodule
